// File: rtl/ff_bank_arbiter_pkg.sv
// Shared definitions for ff_bank_arbiter: FSM state encoding, per-write op encoding,
// and a ceil-log2 helper used to size the round-robin pointer and owner index.
// Latency: n/a (types and constants only). Backpressure: n/a.
package ff_bank_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    localparam logic OP_LOAD   = 1'b0;
    localparam logic OP_TOGGLE = 1'b1;

    // Index width for a count of n items; never narrower than one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/ff_bank_arbiter_rr_pick.sv
// Round-robin picker: first requester at or after ptr, wrapping modulo N.
// Latency: combinational. Backpressure: none; gnt is all-zero when req is all-zero.
// Ports: req (N requests), ptr (search start), gnt (one-hot pick), idx (pick index).
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx
);

    int            c;
    logic [PW-1:0] cidx;
    logic          found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        cidx  = '0;
        for (int i = 0; i < N; i++) begin
            c = int'(ptr) + i;
            if (c >= N) c = c - N;
            cidx = c[PW-1:0];
            if (!found && req[cidx]) begin
                found     = 1'b1;
                gnt[cidx] = 1'b1;
                idx       = cidx;
            end
        end
    end

endmodule

// File: rtl/ff_bank_arbiter.sv
// Round-robin arbiter sharing one W-bit D/T flip-flop bank between N requesters, with lockable bursts.
// Latency: request in cycle t -> registered gnt and updated q in cycle t+1; one gnt=0 bubble after a burst.
// Backpressure: non-owners are stalled (req/lock ignored) while the bank is owned; losers simply retry.
// Ports: clk, rstn (async active-low); req/lock/op per requester; wdata packed N*W;
//        gnt one-hot registered; q bank; qbar = ~q; busy = owned; hold_tmo sticky eviction flag.
// Option: define ARB_HOLD_TIMEOUT_EN to evict an owner after MAX_HOLD owned cycles.
module ff_bank_arbiter
    import ff_bank_arbiter_pkg::*;
#(
    parameter int N        = 4,
    parameter int W        = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   lock,
    input  logic [N-1:0]   op,
    input  logic [N*W-1:0] wdata,
    output logic [N-1:0]   gnt,
    output logic [W-1:0]   q,
    output logic [W-1:0]   qbar,
    output logic           busy,
    output logic           hold_tmo
);

    localparam int PW = clog2(N);

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] owner;
    logic [PW-1:0] pick_idx;
    logic [N-1:0]  pick_oh;
    logic [PW-1:0] ptr_nxt;
    logic [PW-1:0] wr_idx;
    logic          wr_req;
    logic          wr_op;
    logic [W-1:0]  wr_dat;
    logic [W-1:0]  q_nxt;
    logic          hold_exp;

    rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_rr_pick (
        .req (req),
        .ptr (ptr),
        .gnt (pick_oh),
        .idx (pick_idx)
    );

    assign ptr_nxt = (pick_idx == PW'(N - 1)) ? '0 : pick_idx + 1'b1;

    // The writer is the round-robin pick in IDLE and the locked owner in OWN.
    assign wr_idx = (state == OWN) ? owner : pick_idx;

    // Explicit mux so only the selected lane's wdata can reach the bank.
    always_comb begin
        wr_req = 1'b0;
        wr_op  = OP_LOAD;
        wr_dat = '0;
        for (int i = 0; i < N; i++) begin
            if (wr_idx == PW'(i)) begin
                wr_req = req[i];
                wr_op  = op[i];
                wr_dat = wdata[i*W +: W];
            end
        end
    end

    assign q_nxt = (wr_op == OP_TOGGLE) ? (q ^ wr_dat) : wr_dat;
    assign qbar  = ~q;

`ifdef ARB_HOLD_TIMEOUT_EN
    localparam int HW = clog2(MAX_HOLD + 1);

    logic [HW-1:0] hold_cnt;

    // Fires on the edge that closes the MAX_HOLD-th owned cycle.
    assign hold_exp = (state == OWN) && (hold_cnt == HW'(MAX_HOLD - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_cnt <= '0;
            hold_tmo <= 1'b0;
        end else begin
            // Held at zero in IDLE so every OWN entry starts a fresh count.
            if (state == IDLE) hold_cnt <= '0;
            else               hold_cnt <= hold_cnt + 1'b1;
            if (hold_exp) hold_tmo <= 1'b1;
        end
    end
`else
    assign hold_exp = 1'b0;
    // MAX_HOLD is never negative, so this is constant 0.
    assign hold_tmo = (MAX_HOLD < 0);
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            gnt   <= '0;
            q     <= '0;
            ptr   <= '0;
            owner <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt <= pick_oh;
                        q   <= q_nxt;
                        ptr <= ptr_nxt;
                        if (lock[pick_idx]) begin
                            state <= OWN;
                            owner <= pick_idx;
                            busy  <= 1'b1;
                        end
                    end else begin
                        gnt <= '0;
                    end
                end
                OWN: begin
                    if (hold_exp) begin
                        // Eviction edge: no write, owner rejoins round-robin.
                        state <= IDLE;
                        gnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        if (wr_req) q <= q_nxt;
                        if (!lock[owner]) begin
                            state <= IDLE;
                            gnt   <= '0;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ff_bank_arbiter.sv
// Self-checking bench for ff_bank_arbiter (N=4, W=8, MAX_HOLD=4).
// Latency: expects gnt/q one cycle after a request. Backpressure: exercises lock stalls and eviction.
module tb_ff_bank_arbiter;

    logic        clk;
    logic        rstn;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [3:0]  op;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic [7:0]  qbar;
    logic        busy;
    logic        hold_tmo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  lock;
        logic [3:0]  op;
        logic [31:0] wd;
        logic [3:0]  eg;
        logic [7:0]  eq;
        logic        eb;
        logic        et;
    } step_t;

    typedef struct {
        logic [3:0] gnt;
        logic [7:0] q;
        logic       busy;
        logic       tmo;
    } exp_t;

    exp_t sb[$];

    ff_bank_arbiter #(
        .N        (4),
        .W        (8),
        .MAX_HOLD (4)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .req      (req),
        .lock     (lock),
        .op       (op),
        .wdata    (wdata),
        .gnt      (gnt),
        .q        (q),
        .qbar     (qbar),
        .busy     (busy),
        .hold_tmo (hold_tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic step_t mk(input logic [3:0] r, input logic [3:0] l, input logic [3:0] o,
                                 input logic [31:0] w, input logic [3:0] g, input logic [7:0] qq,
                                 input logic b, input logic t);
        step_t s;
        s.req = r; s.lock = l; s.op = o; s.wd = w;
        s.eg = g; s.eq = qq; s.eb = b; s.et = t;
        return s;
    endfunction

    task automatic test_reset();
        exp_t e;
        rstn = 1'b1;
        #1 rstn = 1'b0;
        #1;
        e = '{4'b0000, 8'h00, 1'b0, 1'b0};
        checks++;
        if ({gnt, q, qbar, busy, hold_tmo} !== {e.gnt, e.q, ~e.q, e.busy, e.tmo}) begin
            errors++;
            $display("FAIL reset got gnt=%b q=%h qbar=%h busy=%b tmo=%b want gnt=%b q=%h qbar=%h busy=%b tmo=%b",
                     gnt, q, qbar, busy, hold_tmo, e.gnt, e.q, ~e.q, e.busy, e.tmo);
        end
        rstn = 1'b1;
    endtask

    task automatic test_load();
        step_t st[$];
        exp_t  e;
        // Idle lanes carry X; they must never reach the bank.
        st.push_back(mk(4'b0001, 4'b0000, 4'b0000, {24'hxxxxxx, 8'hA5}, 4'b0001, 8'hA5, 1'b0, 1'b0));
        st.push_back(mk(4'b0000, 4'b0000, 4'b0000, 32'hxxxx_xxxx,      4'b0000, 8'hA5, 1'b0, 1'b0));
        foreach (st[i]) begin
            req = st[i].req; lock = st[i].lock; op = st[i].op; wdata = st[i].wd;
            sb.push_back('{st[i].eg, st[i].eq, st[i].eb, st[i].et});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({gnt, q, qbar, busy, hold_tmo} !== {e.gnt, e.q, ~e.q, e.busy, e.tmo}) begin
                errors++;
                $display("FAIL load[%0d] got gnt=%b q=%h qbar=%h busy=%b tmo=%b want gnt=%b q=%h busy=%b tmo=%b",
                         i, gnt, q, qbar, busy, hold_tmo, e.gnt, e.q, e.busy, e.tmo);
            end
        end
    endtask

    task automatic test_toggle();
        step_t st[$];
        exp_t  e;
        st.push_back(mk(4'b0010, 4'b0000, 4'b0010, 32'h0000_0F00, 4'b0010, 8'hAA, 1'b0, 1'b0));
        st.push_back(mk(4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 8'hAA, 1'b0, 1'b0));
        foreach (st[i]) begin
            req = st[i].req; lock = st[i].lock; op = st[i].op; wdata = st[i].wd;
            sb.push_back('{st[i].eg, st[i].eq, st[i].eb, st[i].et});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({gnt, q, qbar, busy, hold_tmo} !== {e.gnt, e.q, ~e.q, e.busy, e.tmo}) begin
                errors++;
                $display("FAIL toggle[%0d] got gnt=%b q=%h qbar=%h busy=%b tmo=%b want gnt=%b q=%h busy=%b tmo=%b",
                         i, gnt, q, qbar, busy, hold_tmo, e.gnt, e.q, e.busy, e.tmo);
            end
        end
    endtask

    // ptr is 2 here; requester 0 keeps asking with EE and must stay stalled.
    task automatic test_lock();
        step_t st[$];
        exp_t  e;
        st.push_back(mk(4'b0101, 4'b0100, 4'b0000, 32'h0011_00EE, 4'b0100, 8'h11, 1'b1, 1'b0));
        st.push_back(mk(4'b0101, 4'b0100, 4'b0000, 32'h0022_00EE, 4'b0100, 8'h22, 1'b1, 1'b0));
        st.push_back(mk(4'b0101, 4'b0100, 4'b0000, 32'h0033_00EE, 4'b0100, 8'h33, 1'b1, 1'b0));
        st.push_back(mk(4'b0001, 4'b0000, 4'b0000, 32'h0000_005A, 4'b0000, 8'h33, 1'b0, 1'b0));
        st.push_back(mk(4'b0001, 4'b0000, 4'b0000, 32'h0000_005A, 4'b0001, 8'h5A, 1'b0, 1'b0));
        st.push_back(mk(4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 8'h5A, 1'b0, 1'b0));
        foreach (st[i]) begin
            req = st[i].req; lock = st[i].lock; op = st[i].op; wdata = st[i].wd;
            sb.push_back('{st[i].eg, st[i].eq, st[i].eb, st[i].et});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({gnt, q, qbar, busy, hold_tmo} !== {e.gnt, e.q, ~e.q, e.busy, e.tmo}) begin
                errors++;
                $display("FAIL lock[%0d] got gnt=%b q=%h qbar=%h busy=%b tmo=%b want gnt=%b q=%h busy=%b tmo=%b",
                         i, gnt, q, qbar, busy, hold_tmo, e.gnt, e.q, e.busy, e.tmo);
            end
        end
    endtask

    task automatic test_reset_mid_own();
        exp_t e;
        req = 4'b0001; lock = 4'b0001; op = 4'b0000; wdata = 32'h0000_00C3;
        sb.push_back('{4'b0001, 8'hC3, 1'b1, 1'b0});
        @(posedge clk); #1;
        e = sb.pop_front();
        checks++;
        if ({gnt, q, busy} !== {e.gnt, e.q, e.busy}) begin
            errors++;
            $display("FAIL own_entry got gnt=%b q=%h busy=%b want gnt=%b q=%h busy=%b",
                     gnt, q, busy, e.gnt, e.q, e.busy);
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({gnt, q, qbar, busy, hold_tmo} !== {4'b0000, 8'h00, 8'hFF, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_own got gnt=%b q=%h qbar=%h busy=%b tmo=%b want gnt=0000 q=00 qbar=ff busy=0 tmo=0",
                     gnt, q, qbar, busy, hold_tmo);
        end
        req = 4'b0000; lock = 4'b0000; wdata = '0;
        #1 rstn = 1'b1;
    endtask

    // From reset (ptr=0) with all four requesting, grants rotate 0,1,2,3,0.
    task automatic test_fairness();
        exp_t        e;
        int          mptr;
        int          k;
        logic [31:0] wd;
        wd   = 32'h4433_2211;
        mptr = 0;
        for (int i = 0; i < 6; i++) begin
            req = (i < 5) ? 4'b1111 : 4'b0000;
            lock = 4'b0000; op = 4'b0000; wdata = wd;
            if (i < 5) begin
                k    = mptr;
                mptr = (k + 1) % 4;
                sb.push_back('{4'(1 << k), wd[k*8 +: 8], 1'b0, 1'b0});
            end else begin
                sb.push_back('{4'b0000, 8'h11, 1'b0, 1'b0});
            end
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({gnt, q, qbar, busy, hold_tmo} !== {e.gnt, e.q, ~e.q, e.busy, e.tmo}) begin
                errors++;
                $display("FAIL fairness[%0d] got gnt=%b q=%h qbar=%h busy=%b tmo=%b want gnt=%b q=%h busy=%b tmo=%b",
                         i, gnt, q, qbar, busy, hold_tmo, e.gnt, e.q, e.busy, e.tmo);
            end
        end
    endtask

    // Requester 2 toggles with FF on consecutive cycles; idle cycle ends it.
    task automatic test_back_to_back();
        exp_t       e;
        logic [7:0] qm;
        qm = 8'h11;
        for (int i = 0; i < 4; i++) begin
            req = (i < 3) ? 4'b0100 : 4'b0000;
            lock = 4'b0000; op = 4'b0100; wdata = 32'h00FF_0000;
            if (i < 3) begin
                qm = qm ^ 8'hFF;
                sb.push_back('{4'b0100, qm, 1'b0, 1'b0});
            end else begin
                sb.push_back('{4'b0000, qm, 1'b0, 1'b0});
            end
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({gnt, q, qbar, busy, hold_tmo} !== {e.gnt, e.q, ~e.q, e.busy, e.tmo}) begin
                errors++;
                $display("FAIL back_to_back[%0d] got gnt=%b q=%h qbar=%h busy=%b tmo=%b want gnt=%b q=%h busy=%b tmo=%b",
                         i, gnt, q, qbar, busy, hold_tmo, e.gnt, e.q, e.busy, e.tmo);
            end
        end
    endtask

    // Requester 1 holds req+lock; wdata changes every cycle to expose any write on the eviction edge.
    task automatic test_hold();
        step_t st[$];
        exp_t  e;
`ifdef ARB_HOLD_TIMEOUT_EN
        st.push_back(mk(4'b0010, 4'b0010, 4'b0000, 32'h0000_7100, 4'b0010, 8'h71, 1'b1, 1'b0));
        st.push_back(mk(4'b0010, 4'b0010, 4'b0000, 32'h0000_7200, 4'b0010, 8'h72, 1'b1, 1'b0));
        st.push_back(mk(4'b0010, 4'b0010, 4'b0000, 32'h0000_7300, 4'b0010, 8'h73, 1'b1, 1'b0));
        st.push_back(mk(4'b0010, 4'b0010, 4'b0000, 32'h0000_7400, 4'b0010, 8'h74, 1'b1, 1'b0));
        st.push_back(mk(4'b0010, 4'b0010, 4'b0000, 32'h0000_7500, 4'b0000, 8'h74, 1'b0, 1'b1));
        st.push_back(mk(4'b0010, 4'b0010, 4'b0000, 32'h0000_7600, 4'b0010, 8'h76, 1'b1, 1'b1));
        st.push_back(mk(4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 8'h76, 1'b0, 1'b1));
        st.push_back(mk(4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 8'h76, 1'b0, 1'b1));
`else
        for (int i = 0; i < 8; i++) begin
            st.push_back(mk(4'b0010, 4'b0010, 4'b0000, {16'h0000, 8'(8'h71 + i), 8'h00},
                            4'b0010, 8'(8'h71 + i), 1'b1, 1'b0));
        end
        st.push_back(mk(4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 8'h78, 1'b0, 1'b0));
`endif
        foreach (st[i]) begin
            req = st[i].req; lock = st[i].lock; op = st[i].op; wdata = st[i].wd;
            sb.push_back('{st[i].eg, st[i].eq, st[i].eb, st[i].et});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({gnt, q, qbar, busy, hold_tmo} !== {e.gnt, e.q, ~e.q, e.busy, e.tmo}) begin
                errors++;
                $display("FAIL hold[%0d] got gnt=%b q=%h qbar=%h busy=%b tmo=%b want gnt=%b q=%h busy=%b tmo=%b",
                         i, gnt, q, qbar, busy, hold_tmo, e.gnt, e.q, e.busy, e.tmo);
            end
        end
    endtask

    initial begin
        rstn  = 1'b0;
        req   = '0;
        lock  = '0;
        op    = '0;
        wdata = '0;
        test_reset();
        test_load();
        test_toggle();
        test_lock();
        test_reset_mid_own();
        test_fairness();
        test_back_to_back();
        test_hold();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d entries want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
